tile_cfg_bank_programmer: RTL and testbench

Sequences the programming of a tile's bitline/wordline configuration memory bank, one wordline row at a time. It accepts configuration data as a valid/ready word stream, assembles a full row on the `bl` bus, and fires a timed one-hot pulse on the matching `wl` line. One instance sits at the top of each tile column and drives the tile's `bl`/`wl` buses, whose slices feed the grid, connection-block and switch-block instances.

---
 rtl/tile_cfg_pkg.sv | 24 ++
 rtl/cfg_row_assembler.sv | 55 +++++
 rtl/tile_cfg_bank_programmer.sv | 120 ++++++++++++
 tb/tb_tile_cfg_bank_programmer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_cfg_pkg.sv
// Shared types and sizing helpers for the tile configuration bank programmer.
package tile_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } cfg_state_e;

    localparam int STATE_W = 3;

    function automatic int chunks_f(input int bl_width, input int word_w);
        return (bl_width + word_w - 1) / word_w;
    endfunction

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_w_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cfg_row_assembler.sv
// Builds one bitline row from a stream of words: chunk k lands on bits
// k*WORD_W upward, word bit i on row bit k*WORD_W+i; overflow bits are dropped.
module cfg_row_assembler
    import tile_cfg_pkg::*;
#(
    parameter int BL_WIDTH = 10,
    parameter int WORD_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                accept,
    input  logic                row_clr,
    input  logic [WORD_W-1:0]   cfg_data,
    output logic [BL_WIDTH-1:0] bl,
    output logic                last_chunk
);
    localparam int CHUNKS = chunks_f(BL_WIDTH, WORD_W);
    localparam int CW     = cnt_w_f(CHUNKS);
    localparam logic [CW-1:0] CHUNK_LAST = CW'(CHUNKS - 1);

    logic [BL_WIDTH-1:0] bl_q, bl_d;
    logic [CW-1:0]       chunk_q, chunk_d;

    assign last_chunk = (chunk_q == CHUNK_LAST);
    assign bl         = bl_q;

    always_comb begin
        bl_d    = bl_q;
        chunk_d = chunk_q;
        if (row_clr) begin
            chunk_d = '0;
        end else if (accept) begin
            for (int i = 0; i < BL_WIDTH; i++) begin
                if (CW'(i / WORD_W) == chunk_q) begin
                    bl_d[i] = cfg_data[i % WORD_W];
                end
            end
            // Parked on the last chunk; the row is finished before it could wrap.
            if (!last_chunk) begin
                chunk_d = chunk_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bl_q    <= '0;
            chunk_q <= '0;
        end else begin
            bl_q    <= bl_d;
            chunk_q <= chunk_d;
        end
    end

endmodule

// File: rtl/tile_cfg_bank_programmer.sv
// Programs a tile's configuration bank row by row: load a row on bl, then
// pulse the matching wordline for WL_PULSE cycles with setup/hold margins.
module tile_cfg_bank_programmer
    import tile_cfg_pkg::*;
#(
    parameter int NUM_WL   = 4,
    parameter int BL_WIDTH = 10,
    parameter int WORD_W   = 4,
    parameter int WL_PULSE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [WORD_W-1:0]   cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [0:BL_WIDTH-1] bl,
    output logic [0:NUM_WL-1]   wl,
    output logic                busy,
    output logic                done,
    output logic [STATE_W-1:0]  dbg_state
);
    localparam int RW = cnt_w_f(NUM_WL);
    localparam int PW = $clog2(WL_PULSE + 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(NUM_WL - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(WL_PULSE - 1);

    cfg_state_e          state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [PW-1:0]       pulse_q, pulse_d;
    logic [0:NUM_WL-1]   wl_q, wl_d;
    logic                accept, row_clr, last_chunk;
    logic [BL_WIDTH-1:0] row_bits;

    cfg_row_assembler #(
        .BL_WIDTH (BL_WIDTH),
        .WORD_W   (WORD_W)
    ) u_row (
        .clk        (clk),
        .rst        (reset),
        .accept     (accept),
        .row_clr    (row_clr),
        .cfg_data   (cfg_data),
        .bl         (row_bits),
        .last_chunk (last_chunk)
    );

    // Handshake: a word transfers on a rising edge where cfg_valid and
    // cfg_ready are both high; cfg_ready is high exactly while in LOAD. An
    // abort in that same cycle wins, so the word is dropped and bl is kept.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pulse_d = pulse_q;
        row_clr = 1'b0;
        accept  = cfg_valid && (state_q == LOAD) && !abort;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    row_clr = 1'b1;
                end
                LOAD:  if (accept && last_chunk) state_d = SETUP;
                SETUP: begin
                    state_d = PULSE;
                    pulse_d = '0;
                end
                PULSE: begin
                    if (pulse_q == PULSE_LAST) state_d = HOLD;
                    else                       pulse_d = pulse_q + PW'(1);
                end
                HOLD: begin
                    if (row_q == ROW_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                        row_d   = row_q + RW'(1);
                        row_clr = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        wl_d = '0;
        if (state_d == PULSE) wl_d[row_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            pulse_q <= '0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pulse_q <= pulse_d;
            wl_q    <= wl_d;
        end
    end

    // Bus index i on bl carries row bit i.
    always_comb begin
        for (int i = 0; i < BL_WIDTH; i++) bl[i] = row_bits[i];
    end

    assign wl        = wl_q;
    assign cfg_ready = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tile_cfg_bank_programmer.sv
// Randomized bench for tile_cfg_bank_programmer with a row-level reference
// model, an expected-event queue and a negedge monitor.
module tb_tile_cfg_bank_programmer;
  localparam int NUM_WL  = 4;
  localparam int BL      = 10;
  localparam int W       = 4;
  localparam int P       = 2;
  localparam int CHUNKS  = (BL + W - 1) / W;
  localparam int ROW_CYC = CHUNKS + P + 2;
  localparam int EW      = 1 + NUM_WL + BL + 16;
  localparam logic [0:BL-1] FIXED_BL = 10'b0101101011;

  logic clk = 1'b0;
  logic reset, start, abort, cfg_valid;
  logic cfg_ready, busy, done;
  logic [W-1:0] cfg_data;
  logic [0:BL-1] bl;
  logic [0:NUM_WL-1] wl;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  // entry = {is_done, wl, bl, cycles from start to done}
  logic [EW-1:0] exp_q[$];

  logic [0:NUM_WL-1] prev_wl;
  logic [0:BL-1] prev_bl;
  logic prev_done, prev_busy;

  tile_cfg_bank_programmer #(
    .NUM_WL(NUM_WL), .BL_WIDTH(BL), .WORD_W(W), .WL_PULSE(P)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .bl(bl), .wl(wl), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference model: row bit b comes from bit (b mod W) of word (b div W)
  function automatic logic [0:BL-1] model_row(input logic [W-1:0] words[CHUNKS]);
    logic [0:BL-1] r;
    logic [W-1:0] wd;
    for (int b = 0; b < BL; b++) begin
      wd = words[b / W];
      r[b] = wd[b % W];
    end
    return r;
  endfunction

  // driver tasks
  task automatic send_word(input logic [W-1:0] w);
    int budget = 100;
    cfg_valid = 1'b1;
    cfg_data  = w;
    while (cfg_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("send_timeout", cfg_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_pulse(input int r);
    int budget = 100;
    while (wl[r] !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("pulse_seen", wl[r], 1);
  endtask

  // stop_mode: 0 run to done, 1 abort during PULSE of stop_row, 2 async reset there
  task automatic program_bank(input int stall_row, input int stall_len, input int mid_start_row,
                              input int stop_mode, input int stop_row, input bit fixed);
    logic [W-1:0] words[CHUNKS];
    logic [W-1:0] fixed_words[CHUNKS];
    logic [0:BL-1] e;
    logic [0:NUM_WL-1] oh;
    int budget;
    fixed_words = '{4'hA, 4'h5, 4'hF};
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    check("ready_rise", cfg_ready, 1);
    for (int r = 0; r < NUM_WL; r++) begin
      for (int c = 0; c < CHUNKS; c++)
        words[c] = (fixed && r == 0) ? fixed_words[c] : W'($urandom_range(0, (1 << W) - 1));
      e = model_row(words);
      oh = '0;
      oh[r] = 1'b1;
      repeat (P) exp_q.push_back({1'b0, oh, e, 16'd0});
      for (int c = 0; c < CHUNKS; c++) begin
        if (r == stall_row && c == 1) begin
          cfg_valid = 1'b0;
          cfg_data  = W'($urandom);
          repeat (stall_len) begin
            check("stall_ready", cfg_ready, 1);
            check("stall_wl", wl, 0);
            @(negedge clk);
          end
        end
        if (r == mid_start_row && c == 1) start = 1'b1;
        send_word(words[c]);
        if (start) begin
          start = 1'b0;
          check("mid_start_ready", cfg_ready, 1);
          check("mid_start_busy", busy, 1);
        end
      end
      if (fixed && r == 0) begin
        wait_pulse(0);
        check("row0_fixed_bl", bl, FIXED_BL);
      end
      if (stop_mode != 0 && r == stop_row) begin
        cfg_valid = 1'b0;
        wait_pulse(r);
        if (stop_mode == 1) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check("abort_wl", wl, 0);
          check("abort_busy", busy, 0);
          check("abort_done", done, 0);
          check("abort_bl_kept", bl, e);
          exp_q.delete();
        end else begin
          #2 reset = 1'b1;
          #1;
          check("rst_async_wl", wl, 0);
          check("rst_async_bl", bl, 0);
          exp_q.delete();
          @(negedge clk);
          @(negedge clk);
          reset = 1'b0;
          repeat (4) begin
            @(negedge clk);
            check("rst_hold_outputs", {bl, wl, busy, done, cfg_ready}, 0);
          end
        end
        return;
      end
    end
    cfg_valid = 1'b0;
    exp_q.push_back({1'b1, {NUM_WL{1'b0}}, {BL{1'b0}},
                     16'(1 + NUM_WL * ROW_CYC + ((stall_row < NUM_WL) ? stall_len : 0))});
    budget = 300;
    while ((busy || exp_q.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("program_idle", busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [0:NUM_WL-1] e_wl;
    logic [0:BL-1] e_bl;
    if (reset) begin
      prev_wl   <= '0;
      prev_bl   <= bl;
      prev_done <= 1'b0;
      prev_busy <= 1'b0;
    end else begin
      if (wl != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wl", wl, 0);
        end else begin
          e = exp_q.pop_front();
          e_wl = e[EW-2 -: NUM_WL];
          e_bl = e[BL+15 -: BL];
          check("pulse_kind", e[EW-1], 0);
          check("pulse_wl", wl, e_wl);
          check("pulse_bl", bl, e_bl);
        end
        if (prev_wl == '0) begin
          check("setup_bl", bl, prev_bl);
          check("setup_busy", prev_busy, 1);
        end
      end else if (prev_wl != '0) begin
        check("hold_bl", bl, prev_bl);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", e[EW-1], 1);
          check("done_cycle", cyc - start_cyc, e[15:0]);
        end
      end
      if (prev_done) check("busy_after_done", busy, 0);
      prev_wl   <= wl;
      prev_bl   <= bl;
      prev_done <= done;
      prev_busy <= busy;
    end
  end

  // test sequence
  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = '0;
    #1;
    check("reset_wl", wl, 0);
    check("reset_bl", bl, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready", cfg_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wl_rel", wl, 0);
    check("reset_bl_rel", bl, 0);
    check("reset_state_idle", dbg_state, 0);

    cfg_valid = 1'b1;
    cfg_data  = W'($urandom);
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", cfg_ready, 0);
      check("idle_busy", busy, 0);
    end
    cfg_valid = 1'b0;

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_ready", cfg_ready, 0);

    program_bank(NUM_WL, 0, NUM_WL, 0, 0, 1'b1);
    program_bank(1, 5, NUM_WL, 0, 0, 1'b0);
    program_bank(NUM_WL, 0, 1, 0, 0, 1'b0);
    program_bank(NUM_WL, 0, NUM_WL, 1, 2, 1'b0);
    program_bank(NUM_WL, 0, NUM_WL, 0, 0, 1'b0);
    program_bank(NUM_WL, 0, NUM_WL, 2, 1, 1'b0);
    program_bank(NUM_WL, 0, NUM_WL, 0, 0, 1'b0);
    repeat (4) program_bank($urandom_range(0, NUM_WL - 1), $urandom_range(0, 4), NUM_WL, 0, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
